// File: rtl/minute_counter_pkg.sv
// Shared time-keeping constants and wrap helpers for the minute and hour counters.
package minute_counter_pkg;

  localparam int unsigned TIME_W       = 6;
  localparam int unsigned SEC_PER_MIN  = 60;
  localparam int unsigned MIN_PER_HOUR = 60;

  typedef logic [TIME_W-1:0] time_val_t;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'd0,
    ADJ_INC  = 2'd1,
    ADJ_DEC  = 2'd2
  } adj_e;

  // Out-of-range inputs snap back into range rather than propagating.
  function automatic time_val_t wrap_inc(input time_val_t v, input time_val_t last);
    return (v >= last) ? '0 : time_val_t'(v + 1'b1);
  endfunction

  function automatic time_val_t wrap_dec(input time_val_t v, input time_val_t last);
    return ((v == '0) || (v > last)) ? last : time_val_t'(v - 1'b1);
  endfunction

endpackage

// File: rtl/minute_counter_if.sv
// Control and status bundle between the minute counter and its driver.
interface minute_counter_if;
  import minute_counter_pkg::*;

  logic      sec_tick;
  logic      mode;
  logic      add;
  logic      deduct;
  logic      minute;
  time_val_t minute_val;
  time_val_t sec_val;

  modport master (
    output sec_tick, mode, add, deduct,
    input  minute, minute_val, sec_val
  );

  modport slave (
    input  sec_tick, mode, add, deduct,
    output minute, minute_val, sec_val
  );

endinterface

// File: rtl/minute_counter_btn_edge.sv
// Active-low button synchronizer with falling-edge press detection.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;
  logic vld1_q,  vld1_d;
  logic vld2_q,  vld2_d;
  logic arm_q,   arm_d;

  // A button held through reset must be seen released (by a real sample) before it can press.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    arm_d   = arm_q | (vld2_q & sync2_q);
    press   = arm_q & hist_q & ~sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      arm_q   <= arm_d;
    end
  end

endmodule

// File: rtl/minute_counter.sv
// Seconds/minutes counter with run mode rollover carry and set-mode manual adjust.
module minute_counter #(
  parameter int unsigned SEC_PER_MIN  = minute_counter_pkg::SEC_PER_MIN,
  parameter int unsigned MIN_PER_HOUR = minute_counter_pkg::MIN_PER_HOUR
) (
  input logic            clk,
  input logic            rst,
  minute_counter_if.slave bus
);
  import minute_counter_pkg::*;

  localparam time_val_t SEC_LAST = time_val_t'(SEC_PER_MIN - 1);
  localparam time_val_t MIN_LAST = time_val_t'(MIN_PER_HOUR - 1);

  logic      press_add;
  logic      press_ded;
  adj_e      adj;
  time_val_t sec_q, sec_d;
  time_val_t min_q, min_d;
  logic      minute_q, minute_d;

  btn_edge u_add_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.add),
    .press (press_add)
  );

  btn_edge u_ded_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (bus.deduct),
    .press (press_ded)
  );

  // Simultaneous presses cancel; presses outside set mode are dropped.
  always_comb begin
    adj = ADJ_NONE;
    if (bus.mode) begin
      if (press_add && !press_ded) adj = ADJ_INC;
      else if (press_ded && !press_add) adj = ADJ_DEC;
    end
  end

  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    minute_d = 1'b0;
    if (!bus.mode) begin
      if (bus.sec_tick) begin
        if (sec_q >= SEC_LAST) begin
          sec_d    = '0;
          min_d    = wrap_inc(min_q, MIN_LAST);
          minute_d = (min_q >= MIN_LAST);
        end else begin
          sec_d = time_val_t'(sec_q + 1'b1);
        end
      end
    end else begin
      case (adj)
        ADJ_INC: begin
          min_d = wrap_inc(min_q, MIN_LAST);
          sec_d = '0;
        end
        ADJ_DEC: begin
          min_d = wrap_dec(min_q, MIN_LAST);
          sec_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q    <= '0;
      min_q    <= '0;
      minute_q <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      minute_q <= minute_d;
    end
  end

  assign bus.sec_val    = sec_q;
  assign bus.minute_val = min_q;
  assign bus.minute     = minute_q;

endmodule

// File: tb/tb_minute_counter.sv
// Randomized and directed bench for minute_counter against a total-seconds reference model.
module tb_minute_counter;

  localparam int SPM = 60;
  localparam int MPH = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;

  minute_counter_if bus();

  minute_counter #(.SEC_PER_MIN(SPM), .MIN_PER_HOUR(MPH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk     = 0;
  int n_pass    = 0;
  int pulse_cnt = 0;

  // Model: time held as total seconds in the hour; buttons as per-edge sample history since reset.
  int m_total = 0;
  int m_carry = 0;
  int edge_n  = 0;
  bit add_hist[$];
  bit ded_hist[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_total = 0;
    m_carry = 0;
    edge_n  = 0;
    add_hist.delete();
    ded_hist.delete();
  endtask

  // A press lands on edge n when the sample two edges back is low and the one before it high.
  task automatic model_edge();
    bit pa, pd;
    int mn;
    edge_n++;
    add_hist.push_back(bus.add);
    ded_hist.push_back(bus.deduct);
    pa = (edge_n >= 4) && add_hist[edge_n-4] && !add_hist[edge_n-3];
    pd = (edge_n >= 4) && ded_hist[edge_n-4] && !ded_hist[edge_n-3];
    m_carry = 0;
    if (!bus.mode) begin
      if (bus.sec_tick) begin
        m_total = (m_total + 1) % (SPM * MPH);
        m_carry = (m_total == 0) ? 1 : 0;
      end
    end else if (pa != pd) begin
      mn      = m_total / SPM;
      mn      = pa ? (mn + 1) % MPH : (mn + MPH - 1) % MPH;
      m_total = mn * SPM;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    else m_carry = 0;
    @(negedge clk);
    if (bus.minute) pulse_cnt++;
    chk("cyc_min",   int'(bus.minute_val), m_total / SPM);
    chk("cyc_sec",   int'(bus.sec_val),    m_total % SPM);
    chk("cyc_carry", int'(bus.minute),     m_carry);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_min",   int'(bus.minute_val), 0);
    chk("rst_sec",   int'(bus.sec_val),    0);
    chk("rst_carry", int'(bus.minute),     0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.sec_tick = 1'b1;
    repeat (n) step();
    bus.sec_tick = 1'b0;
  endtask

  task automatic push(input bit is_add, input int hold);
    if (is_add) bus.add = 1'b0;
    else        bus.deduct = 1'b0;
    repeat (hold) step();
    bus.add    = 1'b1;
    bus.deduct = 1'b1;
    idle(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sec_tick = 1'b0;
    bus.mode     = 1'b0;
    bus.add      = 1'b1;
    bus.deduct   = 1'b1;
    #2;
    do_reset();
    idle(5);

    // 60 ticks in run mode: one minute, no carry
    pulse_cnt = 0;
    ticks(60);
    idle(2);
    chk("r032_min",   int'(bus.minute_val), 1);
    chk("r032_sec",   int'(bus.sec_val),    0);
    chk("r032_pulse", pulse_cnt,            0);

    // deduct held 10 cycles from 0 in set mode: single wrap to 59 on the third edge
    do_reset();
    idle(5);
    bus.mode   = 1'b1;
    idle(1);
    bus.deduct = 1'b0;
    step();
    step();
    chk("r033_lat2", int'(bus.minute_val), 0);
    step();
    chk("r033_lat3", int'(bus.minute_val), 59);
    repeat (7) step();
    bus.deduct = 1'b1;
    idle(4);
    chk("r033_once",  int'(bus.minute_val), 59);
    chk("r033_pulse", pulse_cnt,            0);

    // 59:30 then add in set mode wraps to 0:00 with no carry
    bus.mode = 1'b0;
    ticks(30);
    chk("r034_pre_sec", int'(bus.sec_val), 30);
    bus.mode = 1'b1;
    idle(1);
    push(1'b1, 2);
    chk("r034_min",   int'(bus.minute_val), 0);
    chk("r034_sec",   int'(bus.sec_val),    0);
    chk("r034_pulse", pulse_cnt,            0);

    // simultaneous add and deduct falls cancel
    push(1'b1, 2);
    push(1'b1, 2);
    bus.add    = 1'b0;
    bus.deduct = 1'b0;
    idle(5);
    bus.add    = 1'b1;
    bus.deduct = 1'b1;
    idle(4);
    chk("r035_min", int'(bus.minute_val), 2);

    // tick coinciding with entry into set mode is ignored
    bus.mode = 1'b0;
    ticks(5);
    bus.mode     = 1'b1;
    bus.sec_tick = 1'b1;
    step();
    bus.sec_tick = 1'b0;
    chk("r023_sec", int'(bus.sec_val), 5);

    // presses in run mode are discarded
    bus.mode = 1'b0;
    idle(2);
    push(1'b1, 3);
    chk("r022_min", int'(bus.minute_val), 2);

    // hour rollover from 59:59
    bus.mode = 1'b1;
    idle(1);
    repeat (3) push(1'b0, 2);
    bus.mode = 1'b0;
    ticks(59);
    chk("r031_pre_min", int'(bus.minute_val), 59);
    chk("r031_pre_sec", int'(bus.sec_val),    59);
    pulse_cnt    = 0;
    bus.sec_tick = 1'b1;
    step();
    bus.sec_tick = 1'b0;
    chk("r031_min",   int'(bus.minute_val), 0);
    chk("r031_sec",   int'(bus.sec_val),    0);
    chk("r031_carry", int'(bus.minute),     1);
    step();
    chk("r031_width", int'(bus.minute), 0);
    chk("r031_count", pulse_cnt,        1);

    // reset landing on the rollover edge suppresses the carry
    bus.mode = 1'b1;
    idle(1);
    push(1'b0, 2);
    bus.mode = 1'b0;
    ticks(59);
    pulse_cnt    = 0;
    bus.sec_tick = 1'b1;
    #2;
    do_reset();
    bus.sec_tick = 1'b0;
    idle(2);
    chk("r027_pulse", pulse_cnt,            0);
    chk("r027_min",   int'(bus.minute_val), 0);

    // reset mid-press with add held: no press until released and pressed again
    bus.mode = 1'b1;
    idle(5);
    bus.add = 1'b0;
    step();
    #2;
    do_reset();
    idle(6);
    chk("r036_held", int'(bus.minute_val), 0);
    bus.add = 1'b1;
    idle(4);
    chk("r036_rel", int'(bus.minute_val), 0);
    bus.add = 1'b0;
    idle(5);
    chk("r036_press", int'(bus.minute_val), 1);
    bus.add = 1'b1;
    idle(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
      bus.sec_tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) bus.add = ~bus.add;
      if ($urandom_range(0, 7) == 0) bus.deduct = ~bus.deduct;
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end
    bus.sec_tick = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
